// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline-stage register with a valid/ready handshake.
//
// Carries one DATA_W-bit payload between two pipeline stages. With SKID=1 a
// second (skid) register absorbs the entry that arrives while downstream stalls,
// so in_ready is a pure state decode and the ready path is cut. With SKID=0 a
// single register is used and in_ready is combinational from out_ready.
// Also keeps a saturating count of back-pressured cycles.
//
// Parameters:
//   DATA_W     payload width (>= 1)
//   RESET_VAL  payload value after reset and after flush
//   SKID       1: 2-entry skid buffer, registered ready; 0: single register
//   CNT_W      stall counter width
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous discard of all held entries
//   in_valid   in   upstream offers in_data
//   in_ready   out  stage can accept this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a valid entry
//   out_ready  in   downstream accepts this cycle
//   out_data   out  payload of the oldest entry
//   occupancy  out  number of held entries (0..2)
//   clr_cnt    in   synchronous clear of stall_cnt
//   stall_cnt  out  saturating count of cycles with out_valid && !out_ready
module pipe_stage_skid #(
  parameter int unsigned          DATA_W    = 32,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0,
  parameter int unsigned          SKID      = 1,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic             UseSkid = (SKID != 0);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   w_main_nxt;
  logic [DATA_W-1:0]   r_skid;
  logic [DATA_W-1:0]   w_skid_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    w_stall_cnt_nxt;

  logic                w_out_valid;
  logic                w_in_ready;
  logic                w_accept;
  logic                w_fire;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign w_out_valid = (r_state != StEmpty);

  // Skid mode: ready depends on state only, so no combinational path from
  // out_ready back to in_ready. Single-register mode: ready whenever the held
  // entry (if any) leaves this cycle.
  assign w_in_ready = UseSkid ? (r_state != StTwo) : (!w_out_valid || out_ready);

  assign w_accept = in_valid && w_in_ready;
  assign w_fire   = w_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Next-state and storage update
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush) begin
      // Flush wins over any handshake: an accepted input is dropped, while a
      // firing output has already been taken by downstream this cycle.
      w_state_nxt = StEmpty;
      w_main_nxt  = RESET_VAL;
      w_skid_nxt  = RESET_VAL;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_state_nxt = StOne;
            w_main_nxt  = in_data;
          end
        end

        StOne: begin
          if (w_accept && w_fire) begin
            w_main_nxt = in_data;
          end else if (w_accept) begin
            // Only reachable with a skid register; without one in_ready is 0
            // whenever an entry is held and not leaving.
            if (UseSkid) begin
              w_state_nxt = StTwo;
              w_skid_nxt  = in_data;
            end
          end else if (w_fire) begin
            // main keeps the departed value; out_data is qualified by out_valid.
            w_state_nxt = StEmpty;
          end
        end

        StTwo: begin
          if (w_fire) begin
            w_state_nxt = StOne;
            w_main_nxt  = r_skid;
          end
        end

        default: begin
          w_state_nxt = StEmpty;
          w_main_nxt  = RESET_VAL;
          w_skid_nxt  = RESET_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
      r_main  <= RESET_VAL;
      r_skid  <= RESET_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter: clear beats increment, saturates instead of wrapping,
  // unaffected by flush.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (clr_cnt) begin
      w_stall_cnt_nxt = '0;
    end else if (w_out_valid && !out_ready && (r_stall_cnt != CntMax)) begin
      w_stall_cnt_nxt = r_stall_cnt + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    occupancy = 2'd0;
    unique case (r_state)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StTwo:   occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: one SKID=1 and one SKID=0 instance share stimulus.
// Each is compared every cycle against a FIFO-level model; directed phases add
// hand-computed literal expectations.
module tb_pipe_stage_skid;

  localparam int unsigned     DW   = 8;
  localparam int unsigned     CW   = 4;
  localparam logic [DW-1:0]   RV   = 8'h5A;
  localparam int              SMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          clr_cnt = 1'b0;

  logic          irdy [2];
  logic          ov   [2];
  logic [DW-1:0] od   [2];
  logic [1:0]    occ  [2];
  logic [CW-1:0] scnt [2];

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .RESET_VAL(RV), .SKID(1), .CNT_W(CW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (irdy[0]),
    .in_data   (in_data),
    .out_valid (ov[0]),
    .out_ready (out_ready),
    .out_data  (od[0]),
    .occupancy (occ[0]),
    .clr_cnt   (clr_cnt),
    .stall_cnt (scnt[0])
  );

  pipe_stage_skid #(.DATA_W(DW), .RESET_VAL(RV), .SKID(0), .CNT_W(CW)) u_noskid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (irdy[1]),
    .in_data   (in_data),
    .out_valid (ov[1]),
    .out_ready (out_ready),
    .out_data  (od[1]),
    .occupancy (occ[1]),
    .clr_cnt   (clr_cnt),
    .stall_cnt (scnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: a FIFO of capacity 2 (k=0) or 1 (k=1) plus the last departed value.
  // ---------------------------------------------------------------------------
  int            m_cnt   [2];
  logic [DW-1:0] m_e     [2][2];
  logic [DW-1:0] m_last  [2];
  int            m_stall [2];

  function automatic logic m_ready(input int k);
    if (k == 0) return m_cnt[0] < 2;
    return (m_cnt[1] == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k]   <= 0;
        m_last[k]  <= RV;
        m_stall[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic int            c    = m_cnt[k];
        automatic logic [DW-1:0] e0   = m_e[k][0];
        automatic logic [DW-1:0] e1   = m_e[k][1];
        automatic logic [DW-1:0] last = m_last[k];
        automatic int            st   = m_stall[k];
        automatic logic          acc  = in_valid && m_ready(k);
        automatic logic          fire = (c > 0) && out_ready;
        if (clr_cnt) st = 0;
        else if (c > 0 && !out_ready && st < SMAX) st = st + 1;
        if (fire) begin
          last = e0;
          e0   = e1;
          c    = c - 1;
        end
        if (acc && !flush) begin
          if (c == 0) e0 = in_data;
          else        e1 = in_data;
          c = c + 1;
        end
        if (flush) begin
          c    = 0;
          last = RV;
        end
        m_cnt[k]   <= c;
        m_e[k][0]  <= e0;
        m_e[k][1]  <= e1;
        m_last[k]  <= last;
        m_stall[k] <= st;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_cnt[k] > 0));
        chk($sformatf("occupancy[%0d]", k), 32'(occ[k]), 32'(m_cnt[k]));
        chk($sformatf("out_data[%0d]", k), 32'(od[k]),
            32'((m_cnt[k] > 0) ? m_e[k][0] : m_last[k]));
        chk($sformatf("in_ready[%0d]", k), 32'(irdy[k]), 32'(m_ready(k)));
        chk($sformatf("stall_cnt[%0d]", k), 32'(scnt[k]), 32'(m_stall[k]));
      end
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    // Reset values
    chk("rst out_valid", 32'(ov[0]), 32'd0);
    chk("rst occupancy", 32'(occ[0]), 32'd0);
    chk("rst out_data", 32'(od[0]), 32'(RV));
    chk("rst in_ready skid", 32'(irdy[0]), 32'd1);
    chk("rst in_ready noskid", 32'(irdy[1]), 32'd1);
    chk("rst stall_cnt", 32'(scnt[0]), 32'd0);
    #2 rst_n = 1'b1;

    // Streaming with out_ready=1: one-cycle latency, full throughput
    edge1();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(8'h11 + i);
      @(negedge clk);
      if (i > 0) chk("stream data", 32'(od[0]), 32'(8'h11 + i - 1));
      if (i > 0) chk("stream data noskid", 32'(od[1]), 32'(8'h11 + i - 1));
      chk("stream in_ready", 32'(irdy[0]), 32'd1);
      edge1();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream last", 32'(od[0]), 32'h18);
    chk("stream stall", 32'(scnt[0]), 32'd0);
    edge1();

    // Back-pressure on the skid instance
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    edge1();
    in_data = 8'hA2;
    edge1();
    in_data = 8'hA3;
    @(negedge clk);
    chk("bp occupancy", 32'(occ[0]), 32'd2);
    chk("bp in_ready", 32'(irdy[0]), 32'd0);
    chk("bp noskid ready", 32'(irdy[1]), 32'd0);
    edge1();
    edge1();
    edge1();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp head A1", 32'(od[0]), 32'hA1);
    chk("bp stall", 32'(scnt[0]), 32'd4);
    edge1();
    @(negedge clk);
    chk("bp head A2", 32'(od[0]), 32'hA2);
    chk("bp ready back", 32'(irdy[0]), 32'd1);
    edge1();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp head A3", 32'(od[0]), 32'hA3);
    edge1();
    @(negedge clk);
    chk("bp drained", 32'(ov[0]), 32'd0);
    chk("bp stall held", 32'(scnt[0]), 32'd4);

    // Flush with both entries full and a simultaneous offer of 0xBB
    edge1();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hC1;
    edge1();
    in_data = 8'hC2;
    edge1();
    in_data = 8'hBB;
    flush   = 1'b1;
    @(negedge clk);
    chk("pre-flush occ", 32'(occ[0]), 32'd2);
    edge1();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush out_valid", 32'(ov[0]), 32'd0);
    chk("flush occupancy", 32'(occ[0]), 32'd0);
    chk("flush out_data", 32'(od[0]), 32'(RV));
    edge1();
    @(negedge clk);
    chk("flush no BB", 32'(ov[0]), 32'd0);

    // SKID=0: in_ready follows out_ready within the cycle
    edge1();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h33;
    edge1();
    in_data = 8'h34;
    @(negedge clk);
    chk("noskid ready low", 32'(irdy[1]), 32'd0);
    chk("noskid valid", 32'(ov[1]), 32'd1);
    #1 out_ready = 1'b1;
    #1 chk("noskid ready comb", 32'(irdy[1]), 32'd1);
    edge1();
    @(negedge clk);
    chk("noskid occ", 32'(occ[1]), 32'd1);
    chk("noskid data", 32'(od[1]), 32'h34);

    // Stall counter saturation and clear
    edge1();
    out_ready = 1'b0;
    in_data   = 8'h44;
    for (int i = 0; i < 20; i++) edge1();
    @(negedge clk);
    chk("sat skid", 32'(scnt[0]), 32'd15);
    chk("sat noskid", 32'(scnt[1]), 32'd15);
    edge1();
    clr_cnt = 1'b1;
    edge1();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr zero", 32'(scnt[0]), 32'd0);
    edge1();
    @(negedge clk);
    chk("clr then one", 32'(scnt[0]), 32'd1);
    chk("still TWO", 32'(occ[0]), 32'd2);

    // Asynchronous reset between edges while in TWO
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_valid", 32'(ov[0]), 32'd0);
    chk("arst occupancy", 32'(occ[0]), 32'd0);
    chk("arst out_data", 32'(od[0]), 32'(RV));
    chk("arst stall", 32'(scnt[0]), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_valid = 1'b0;

    // Randomised traffic with phases of varying back-pressure
    for (int i = 0; i < 3000; i++) begin
      automatic int bias = (i / 250) % 4;
      edge1();
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) >= bias);
      flush     = ($urandom_range(0, 49) == 0);
      clr_cnt   = ($urandom_range(0, 79) == 0);
    end
    edge1();
    in_valid = 1'b0;
    flush    = 1'b0;
    clr_cnt  = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
